uart_fifo_periph: RTL and testbench

Parametrised successor to the single-cycle core's UART peripheral. Memory-mapped UART with independent TX and RX FIFOs, programmable baud divisor and frame format (data bits, parity, stop bits), sticky error flags and a level interrupt. It sits on the core's register bus (we/re, reg_num, wd/rd) and drives the external tx/rx pins.

---
 rtl/uart_fifo_periph_pkg.sv | 47 ++++
 rtl/uart_fifo_periph_sync_fifo.sv | 69 ++++++
 rtl/uart_fifo_periph.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_fifo_periph.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_periph_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared constants for the FIFO-buffered UART peripheral:
//               register indices, CTRL/STATUS bit positions and the
//               TX/RX state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register indices on reg_num
    localparam logic [2:0] c_REG_TXDATA = 3'd0;
    localparam logic [2:0] c_REG_RXDATA = 3'd1;
    localparam logic [2:0] c_REG_CTRL   = 3'd2;
    localparam logic [2:0] c_REG_BAUD   = 3'd3;
    localparam logic [2:0] c_REG_STATUS = 3'd4;
    localparam logic [2:0] c_REG_IRQ_EN = 3'd5;

    // CTRL bit positions
    localparam int c_CTRL_TX_EN     = 0;
    localparam int c_CTRL_RX_EN     = 1;
    localparam int c_CTRL_PAR_EN    = 2;
    localparam int c_CTRL_PAR_ODD   = 3;
    localparam int c_CTRL_STOP2     = 4;
    localparam int c_CTRL_NBITS_LSB = 5;

    // STATUS bit positions (sticky, write-1-to-clear)
    localparam int c_STAT_PAR_ERR = 4;
    localparam int c_STAT_FRM_ERR = 5;
    localparam int c_STAT_OVR     = 6;

    // TX state encoding
    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_START  = 3'd1;
    localparam logic [2:0] c_TX_DATA   = 3'd2;
    localparam logic [2:0] c_TX_PARITY = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd4;

    // RX state encoding
    localparam logic [2:0] c_RX_IDLE   = 3'd0;
    localparam logic [2:0] c_RX_START  = 3'd1;
    localparam logic [2:0] c_RX_DATA   = 3'd2;
    localparam logic [2:0] c_RX_PARITY = 3'd3;
    localparam logic [2:0] c_RX_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_periph_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO. A push on a full FIFO succeeds only when
//               a pop happens in the same cycle; a pop on an empty FIFO is
//               ignored. o_dout shows the head entry (undefined when empty).
// Ports       : clk, rst_n (async active-low) ; i_push/i_din write side ;
//               i_pop read side ; o_dout head ; o_full/o_empty/o_count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_din,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_dout,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_fifo_periph.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_periph
// Description : Memory-mapped UART with TX/RX FIFOs, programmable baud
//               divisor and frame format, sticky error flags and a level IRQ.
// Ports       : clk, rst_n (async active-low)
//               we/re/reg_num/wd/rd : register bus (rd combinational)
//               rx (async serial in), tx (serial out), irq (level)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_periph
    import uart_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              FIFO_DEPTH = 8,
    parameter int              DIV_W      = 16,
    parameter logic [DIV_W-1:0] RESET_DIV = 16'd127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  reg_num,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam logic [3:0] c_NBITS_MAX = 4'(DATA_W);
    localparam int         c_CNT_W     = $clog2(FIFO_DEPTH + 1);

    // ---------------- Register file ----------------
    logic             r_tx_en, r_rx_en, r_par_en, r_par_odd, r_stop2;
    logic [3:0]       r_nbits;
    logic [DIV_W-1:0] r_baud;
    logic [6:0]       r_irq_en;
    logic             r_par_err, r_frm_err, r_ovr;

    logic [3:0] w_nbits_in;
    logic       w_nbits_ok, w_w1c;
    assign w_nbits_in = wd[c_CTRL_NBITS_LSB +: 4];
    assign w_nbits_ok = (w_nbits_in >= 4'd5) && (w_nbits_in <= c_NBITS_MAX);
    assign w_w1c      = we && (reg_num == c_REG_STATUS);

    // ---------------- FIFOs ----------------
    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [DATA_W-1:0] w_tx_dout;
    logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [DATA_W-1:0] w_rx_dout, w_rx_push_data;
    logic [c_CNT_W-1:0] w_tx_count, w_rx_count;

    assign w_tx_push = we && (reg_num == c_REG_TXDATA);
    assign w_rx_pop  = re && (reg_num == c_REG_RXDATA) && !w_rx_empty;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_din(wd[DATA_W-1:0]),
        .i_pop(w_tx_pop), .o_dout(w_tx_dout), .o_full(w_tx_full),
        .o_empty(w_tx_empty), .o_count(w_tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_din(w_rx_push_data),
        .i_pop(w_rx_pop), .o_dout(w_rx_dout), .o_full(w_rx_full),
        .o_empty(w_rx_empty), .o_count(w_rx_count)
    );

    // FIFO occupancy and the upper write-data bits are not part of the map
    logic w_unused;
    assign w_unused = ^{w_tx_count, w_rx_count, wd};

    // ---------------- TX path ----------------
    logic [2:0]        r_tx_state;
    logic [DIV_W-1:0]  r_tx_cnt, r_tx_div;
    logic [3:0]        r_tx_bit, r_tx_nbits;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_par, r_tx_par_en, r_tx_par_odd, r_tx_stop2, r_tx_stop_left, r_tx;
    logic              w_tx_done, w_tx_start, w_tx_busy;

    assign w_tx_done  = (r_tx_cnt == '0);
    // A waiting byte starts right out of the last stop bit, with no idle gap
    assign w_tx_start = r_tx_en && !w_tx_empty &&
                        ((r_tx_state == c_TX_IDLE) ||
                         ((r_tx_state == c_TX_STOP) && w_tx_done && !r_tx_stop_left));
    assign w_tx_pop   = w_tx_start;
    assign w_tx_busy  = (r_tx_state != c_TX_IDLE);
    assign tx         = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= c_TX_IDLE;  r_tx <= 1'b1;
            r_tx_cnt <= '0;  r_tx_div <= '0;  r_tx_bit <= '0;  r_tx_nbits <= '0;
            r_tx_shift <= '0;  r_tx_par <= 1'b0;  r_tx_par_en <= 1'b0;
            r_tx_par_odd <= 1'b0;  r_tx_stop2 <= 1'b0;  r_tx_stop_left <= 1'b0;
        end else if (w_tx_start) begin
            // Frame format is latched here so mid-frame register writes wait
            r_tx_state <= c_TX_START;  r_tx <= 1'b0;
            r_tx_cnt <= r_baud;  r_tx_div <= r_baud;  r_tx_nbits <= r_nbits;
            r_tx_par_en <= r_par_en;  r_tx_par_odd <= r_par_odd;  r_tx_stop2 <= r_stop2;
            r_tx_shift <= w_tx_dout;
        end else if (r_tx_state == c_TX_IDLE) begin
            r_tx <= 1'b1;
        end else if (!w_tx_done) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
        end else begin
            r_tx_cnt <= r_tx_div;
            case (r_tx_state)
                c_TX_START: begin
                    r_tx_state <= c_TX_DATA;  r_tx_bit <= '0;
                    r_tx <= r_tx_shift[0];  r_tx_par <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                end
                c_TX_DATA: begin
                    if (r_tx_bit == r_tx_nbits - 4'd1) begin
                        if (r_tx_par_en) begin
                            r_tx_state <= c_TX_PARITY;  r_tx <= r_tx_par ^ r_tx_par_odd;
                        end else begin
                            r_tx_state <= c_TX_STOP;  r_tx <= 1'b1;  r_tx_stop_left <= r_tx_stop2;
                        end
                    end else begin
                        r_tx_bit <= r_tx_bit + 4'd1;  r_tx <= r_tx_shift[0];
                        r_tx_par <= r_tx_par ^ r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                c_TX_PARITY: begin
                    r_tx_state <= c_TX_STOP;  r_tx <= 1'b1;  r_tx_stop_left <= r_tx_stop2;
                end
                c_TX_STOP: begin
                    if (r_tx_stop_left) r_tx_stop_left <= 1'b0;
                    else                r_tx_state <= c_TX_IDLE;
                end
                default: begin
                    r_tx_state <= c_TX_IDLE;  r_tx <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic              r_rx_s1, r_rx_s2, r_rx_prev;
    logic [2:0]        r_rx_state;
    logic [DIV_W-1:0]  r_rx_cnt, r_rx_div;
    logic [3:0]        r_rx_bit, r_rx_nbits;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_par, r_rx_par_en, r_rx_par_odd, r_rx_perr;
    logic              w_rx_done, w_rx_fall;

    assign w_rx_done = (r_rx_cnt == '0);
    assign w_rx_fall = r_rx_prev && !r_rx_s2;
    assign w_rx_push = (r_rx_state == c_RX_STOP) && w_rx_done;
    // Bits enter at the MSB; short frames are shifted down to bit 0
    assign w_rx_push_data = r_rx_shift >> (c_NBITS_MAX - r_rx_nbits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;  r_rx_s2 <= 1'b1;  r_rx_prev <= 1'b1;
            r_rx_state <= c_RX_IDLE;  r_rx_cnt <= '0;  r_rx_div <= '0;
            r_rx_bit <= '0;  r_rx_nbits <= '0;  r_rx_shift <= '0;
            r_rx_par <= 1'b0;  r_rx_par_en <= 1'b0;  r_rx_par_odd <= 1'b0;  r_rx_perr <= 1'b0;
        end else begin
            r_rx_s1 <= rx;  r_rx_s2 <= r_rx_s1;  r_rx_prev <= r_rx_s2;
            if (r_rx_state == c_RX_IDLE) begin
                if (r_rx_en && w_rx_fall) begin
                    r_rx_state <= c_RX_START;  r_rx_cnt <= r_baud >> 1;
                    r_rx_div <= r_baud;  r_rx_nbits <= r_nbits;
                    r_rx_par_en <= r_par_en;  r_rx_par_odd <= r_par_odd;  r_rx_perr <= 1'b0;
                end
            end else if (!w_rx_done) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end else begin
                r_rx_cnt <= r_rx_div;
                case (r_rx_state)
                    c_RX_START: begin
                        // Line back high at mid-start: treat as a glitch
                        if (r_rx_s2) r_rx_state <= c_RX_IDLE;
                        else begin
                            r_rx_state <= c_RX_DATA;  r_rx_bit <= '0;
                            r_rx_shift <= '0;  r_rx_par <= 1'b0;
                        end
                    end
                    c_RX_DATA: begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};
                        r_rx_par   <= r_rx_par ^ r_rx_s2;
                        if (r_rx_bit == r_rx_nbits - 4'd1)
                            r_rx_state <= r_rx_par_en ? c_RX_PARITY : c_RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 4'd1;
                    end
                    c_RX_PARITY: begin
                        r_rx_perr  <= r_rx_s2 ^ r_rx_par ^ r_rx_par_odd;
                        r_rx_state <= c_RX_STOP;
                    end
                    default: r_rx_state <= c_RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- Registers and sticky flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_en <= 1'b0;  r_rx_en <= 1'b0;  r_par_en <= 1'b0;
            r_par_odd <= 1'b0;  r_stop2 <= 1'b0;  r_nbits <= c_NBITS_MAX;
            r_baud <= RESET_DIV;  r_irq_en <= '0;
            r_par_err <= 1'b0;  r_frm_err <= 1'b0;  r_ovr <= 1'b0;
        end else begin
            if (we && (reg_num == c_REG_CTRL)) begin
                r_tx_en   <= wd[c_CTRL_TX_EN];
                r_rx_en   <= wd[c_CTRL_RX_EN];
                r_par_en  <= wd[c_CTRL_PAR_EN];
                r_par_odd <= wd[c_CTRL_PAR_ODD];
                r_stop2   <= wd[c_CTRL_STOP2];
                r_nbits   <= w_nbits_ok ? w_nbits_in : c_NBITS_MAX;
            end
            if (we && (reg_num == c_REG_BAUD))
                r_baud <= (wd[DIV_W-1:0] == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : wd[DIV_W-1:0];
            if (we && (reg_num == c_REG_IRQ_EN))
                r_irq_en <= wd[6:0];
            // Hardware set is OR-ed in after the clear so it wins a collision
            r_par_err <= (r_par_err & ~(w_w1c & wd[c_STAT_PAR_ERR])) | (w_rx_push & r_rx_perr);
            r_frm_err <= (r_frm_err & ~(w_w1c & wd[c_STAT_FRM_ERR])) | (w_rx_push & ~r_rx_s2);
            r_ovr     <= (r_ovr & ~(w_w1c & wd[c_STAT_OVR])) | (w_rx_push & w_rx_full & ~w_rx_pop);
        end
    end

    logic [7:0] w_status;
    assign w_status = {w_tx_busy, r_ovr, r_frm_err, r_par_err,
                       w_rx_full, ~w_rx_empty, w_tx_full, w_tx_empty};
    assign irq = |(w_status[6:0] & r_irq_en);

    always_comb begin
        rd = '0;
        case (reg_num)
            c_REG_RXDATA: rd = w_rx_empty ? 32'd0 : 32'(w_rx_dout);
            c_REG_CTRL:   rd = {23'd0, r_nbits, r_stop2, r_par_odd, r_par_en, r_rx_en, r_tx_en};
            c_REG_BAUD:   rd = 32'(r_baud);
            c_REG_STATUS: rd = {24'd0, w_status};
            c_REG_IRQ_EN: rd = {25'd0, r_irq_en};
            default:      rd = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_periph
// Description : Scoreboard bench for uart_fifo_periph. Stimulus pushes the
//               expected value of each observation into a queue; a monitor
//               pops and compares on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_periph;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [2:0]  reg_num = 3'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        tx;
    logic        irq;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rx_w;

    assign rx_w = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_periph #(
        .DATA_W(8), .FIFO_DEPTH(8), .DIV_W(16), .RESET_DIV(16'd127)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .reg_num(reg_num),
        .wd(wd), .rd(rd), .rx(rx_w), .tx(tx), .irq(irq)
    );

    typedef struct {
        string       name;
        int          sel;      // 0 = rd, 1 = tx, 2 = irq
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_req = 1'b0;

    // Monitor: pops one expectation per requested observation
    always @(negedge clk) begin
        if (mon_req) begin
            exp_t        it;
            logic [31:0] act;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty: observation with no expected value");
            end else begin
                it = exp_q.pop_front();
                case (it.sel)
                    0:       act = rd;
                    1:       act = {31'd0, tx};
                    default: act = {31'd0, irq};
                endcase
                if (act !== it.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
                end
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic observe(input string nm, input int sel, input logic [2:0] r,
                           input logic [31:0] e, input logic pop);
        reg_num = r;
        re      = pop;
        exp_q.push_back('{nm, sel, e});
        mon_req = 1'b1;
        @(negedge clk);
        #1 mon_req = 1'b0;
        @(posedge clk);
        #1 re = 1'b0;
    endtask

    task automatic chk_reg(input string nm, input logic [2:0] r, input logic [31:0] e);
        observe(nm, 0, r, e, 1'b0);
    endtask

    task automatic chk_pop(input string nm, input logic [31:0] e);
        observe(nm, 0, 3'd1, e, 1'b1);
    endtask

    task automatic chk_tx(input string nm, input logic e);
        observe(nm, 1, 3'd7, {31'd0, e}, 1'b0);
    endtask

    task automatic chk_irq(input string nm, input logic e);
        observe(nm, 2, 3'd7, {31'd0, e}, 1'b0);
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        reg_num = r;
        wd      = d;
        we      = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the start bit began (cycle index 1 of the frame)
    task automatic wait_tx_low(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_start_timeout: got no start bit within %0d cycles expected one", budget);
        end
        #1;
        @(posedge clk);
        #1;
    endtask

    // Drive one 8-bit frame on rx at 4 cycles per bit (BAUD = 3)
    task automatic send_rx(input logic [7:0] d, input logic with_par,
                           input logic par_bit, input logic stop_bit);
        rx_drv = 1'b0;
        idle(4);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            idle(4);
        end
        if (with_par) begin
            rx_drv = par_bit;
            idle(4);
        end
        rx_drv = stop_bit;
        idle(4);
        rx_drv = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] byte_v;
        logic       exp_bit;
        int         seg;

        // ---- Reset values ----
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        chk_reg("rst_txdata", 3'd0, 32'h0);
        chk_reg("rst_rxdata", 3'd1, 32'h0);
        chk_reg("rst_ctrl",   3'd2, 32'h100);
        chk_reg("rst_baud",   3'd3, 32'h7F);
        chk_reg("rst_status", 3'd4, 32'h01);
        chk_reg("rst_irq_en", 3'd5, 32'h0);
        chk_reg("rst_reg6",   3'd6, 32'h0);
        chk_reg("rst_reg7",   3'd7, 32'h0);
        chk_tx ("rst_tx", 1'b1);
        chk_irq("rst_irq", 1'b0);

        // ---- TX frame 0xA5, 8N1, 4 cycles per bit ----
        wr(3'd3, 32'd3);
        wr(3'd2, 32'h101);
        chk_reg("ctrl_8n1", 3'd2, 32'h101);
        wr(3'd0, 32'hA5);
        wait_tx_low(50);
        byte_v = 8'hA5;
        for (int i = 1; i < 40; i++) begin
            seg = i / 4;
            if (seg == 0)      exp_bit = 1'b0;
            else if (seg <= 8) exp_bit = byte_v[seg-1];
            else               exp_bit = 1'b1;
            chk_tx($sformatf("tx_a5_cyc%0d", i), exp_bit);
        end
        chk_reg("tx_done_status", 3'd4, 32'h01);

        // ---- Loopback with odd parity ----
        loop = 1'b1;
        wr(3'd2, 32'h10F);
        wr(3'd0, 32'h3C);
        wr(3'd0, 32'h00);
        wr(3'd0, 32'hFF);
        idle(170);
        chk_reg("loop_status", 3'd4, 32'h05);
        chk_pop("loop_rx0", 32'h3C);
        chk_pop("loop_rx1", 32'h00);
        chk_pop("loop_rx2", 32'hFF);
        chk_reg("loop_status_empty", 3'd4, 32'h01);

        // ---- Parity error then framing error, IRQ ----
        loop = 1'b0;
        wr(3'd2, 32'h106);
        wr(3'd5, 32'h30);
        send_rx(8'h55, 1'b1, 1'b1, 1'b1);
        idle(6);
        chk_reg("perr_status", 3'd4, 32'h15);
        chk_irq("perr_irq", 1'b1);
        send_rx(8'h55, 1'b1, 1'b0, 1'b0);
        idle(6);
        chk_reg("ferr_status", 3'd4, 32'h35);
        chk_irq("ferr_irq", 1'b1);
        wr(3'd4, 32'h30);
        chk_reg("w1c_status", 3'd4, 32'h05);
        chk_irq("w1c_irq", 1'b0);
        chk_pop("err_rx0", 32'h55);
        chk_pop("err_rx1", 32'h55);
        chk_reg("err_status_empty", 3'd4, 32'h01);

        // ---- RX overrun: FIFO_DEPTH + 1 frames ----
        wr(3'd2, 32'h102);
        for (int i = 0; i < 9; i++) begin
            send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        end
        idle(6);
        chk_reg("ovr_status", 3'd4, 32'h4D);
        for (int i = 0; i < 8; i++) begin
            chk_pop($sformatf("ovr_rx%0d", i), 32'h10 + 32'(i));
        end
        chk_reg("ovr_status_sticky", 3'd4, 32'h41);
        wr(3'd4, 32'h40);
        chk_reg("ovr_cleared", 3'd4, 32'h01);

        // ---- TX FIFO full, ninth byte dropped ----
        wr(3'd2, 32'h0);
        for (int i = 0; i < 9; i++) begin
            wr(3'd0, 32'h80 + 32'(i));
        end
        chk_reg("txfull_status", 3'd4, 32'h02);
        loop = 1'b1;
        wr(3'd2, 32'h103);
        idle(380);
        chk_reg("txfull_drain_status", 3'd4, 32'h0D);
        for (int i = 0; i < 8; i++) begin
            chk_pop($sformatf("txfull_rx%0d", i), 32'h80 + 32'(i));
        end
        chk_pop("rx_empty_pop", 32'h0);
        chk_reg("txfull_final_status", 3'd4, 32'h01);

        // ---- Reset during DATA bit 3 ----
        loop = 1'b0;
        wr(3'd2, 32'h101);
        wr(3'd0, 32'h00);
        wr(3'd0, 32'h00);
        wait_tx_low(50);
        idle(16);
        chk_tx("tx_bit3_low", 1'b0);
        rst_n = 1'b0;
        chk_tx("tx_async_reset", 1'b1);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk_reg("post_rst_status", 3'd4, 32'h01);
        chk_reg("post_rst_ctrl",   3'd2, 32'h100);
        chk_reg("post_rst_baud",   3'd3, 32'h7F);
        chk_tx ("post_rst_tx", 1'b1);

        // ---- 20 ns glitch on rx at BAUD = 127 ----
        wr(3'd2, 32'h102);
        wr(3'd5, 32'h70);
        rx_drv = 1'b0;
        #20 rx_drv = 1'b1;
        idle(300);
        chk_reg("glitch_status", 3'd4, 32'h01);
        chk_pop("glitch_rxdata", 32'h0);
        chk_irq("glitch_irq", 1'b0);

        idle(2);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
